spi_frame_streamer: RTL and testbench

//  Upstream feeder for SPI_Master_With_Single_CS. Buffers host bytes grouped into frames.

---
 rtl/spi_stream_pkg.sv | 16 +
 rtl/spi_sync_fifo.sv | 56 +++++
 rtl/spi_frame_streamer.sv | 173 +++++++++++++++++
 tb/tb_spi_frame_streamer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_stream_pkg.sv
// Shared types and helpers for the SPI frame streamer and its FIFOs.
package spi_stream_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_DRAIN
    } stream_state_t;

    function automatic int cnt_w(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous FIFO with a first-word-fall-through head; push when full and pop when empty are ignored.
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Push,
    input  logic [WIDTH-1:0] i_Data,
    input  logic             i_Pop,
    output logic [WIDTH-1:0] o_Data,
    output logic             o_Full,
    output logic             o_Empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_Full  = (r_count == (AW+1)'(DEPTH));
    assign o_Empty = (r_count == '0);
    assign w_push  = i_Push && !o_Full;
    assign w_pop   = i_Pop && !o_Empty;
    assign o_Data  = r_mem[r_rd_ptr];

    always_ff @(posedge i_Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_Data;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spi_frame_streamer.sv
// Buffers host bytes into frames and feeds an SPI master one frame per chip-select,
// tagging returned bytes with their frame position.
module spi_frame_streamer
    import spi_stream_pkg::*;
#(
    parameter int  MAX_BYTES_PER_CS = 4,
    parameter int  DATA_DEPTH       = 16,
    parameter int  LEN_DEPTH        = 4,
    localparam int CW               = cnt_w(MAX_BYTES_PER_CS)
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    input  logic          i_Wr_DV,
    input  logic [7:0]    i_Wr_Byte,
    input  logic          i_Wr_Last,
    output logic          o_Wr_Ready,
    output logic [CW-1:0] o_TX_Count,
    output logic [7:0]    o_TX_Byte,
    output logic          o_TX_DV,
    input  logic          i_TX_Ready,
    input  logic          i_RX_DV,
    input  logic [7:0]    i_RX_Byte,
    output logic          o_RX_DV,
    output logic [7:0]    o_RX_Byte,
    output logic          o_RX_Last,
    output logic          o_Busy,
    output logic          o_Err_Len
);
    stream_state_t r_state;
    stream_state_t w_state_next;

    logic [CW-1:0] r_wr_cnt;
    logic [CW-1:0] r_rem;
    logic [CW-1:0] r_rx_cnt;
    logic [CW-1:0] r_tx_count;
    logic [7:0]    r_tx_byte;
    logic          r_wait_skip;
    logic          r_err_len;
    logic          r_rx_dv;
    logic [7:0]    r_rx_byte;
    logic          r_rx_last;

    logic          w_wr_accept;
    logic [CW-1:0] w_wr_cnt_inc;
    logic          w_wr_at_max;
    logic          w_len_push;
    logic          w_len_pop;
    logic          w_data_pop;
    logic          w_data_full;
    logic          w_data_empty;
    logic          w_len_full;
    logic          w_len_empty;
    logic [7:0]    w_data_head;
    logic [CW-1:0] w_len_head;

    assign o_Wr_Ready   = !w_data_full && !w_len_full;
    assign w_wr_accept  = i_Wr_DV && o_Wr_Ready;
    assign w_wr_cnt_inc = r_wr_cnt + CW'(1);
    assign w_wr_at_max  = (w_wr_cnt_inc == CW'(MAX_BYTES_PER_CS));
    assign w_len_push   = w_wr_accept && (i_Wr_Last || w_wr_at_max);

    spi_sync_fifo #(.WIDTH(8), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Push  (w_wr_accept),
        .i_Data  (i_Wr_Byte),
        .i_Pop   (w_data_pop),
        .o_Data  (w_data_head),
        .o_Full  (w_data_full),
        .o_Empty (w_data_empty)
    );

    spi_sync_fifo #(.WIDTH(CW), .DEPTH(LEN_DEPTH)) u_len_fifo (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Push  (w_len_push),
        .i_Data  (w_wr_cnt_inc),
        .i_Pop   (w_len_pop),
        .o_Data  (w_len_head),
        .o_Full  (w_len_full),
        .o_Empty (w_len_empty)
    );

    // The master drops TX_Ready one cycle after DV, so the first WAIT cycle is blind.
    always_comb begin
        w_state_next = r_state;
        w_len_pop    = 1'b0;
        w_data_pop   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_len_empty && i_TX_Ready) begin
                    w_len_pop    = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_data_pop   = !w_data_empty;
                w_state_next = S_SEND;
            end
            S_SEND: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (!r_wait_skip && i_TX_Ready) begin
                    if (r_rem != '0) begin
                        w_data_pop   = !w_data_empty;
                        w_state_next = S_SEND;
                    end else begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (r_rx_cnt == r_tx_count) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state     <= S_IDLE;
            r_wr_cnt    <= '0;
            r_rem       <= '0;
            r_rx_cnt    <= '0;
            r_tx_count  <= '0;
            r_tx_byte   <= '0;
            r_wait_skip <= 1'b0;
            r_err_len   <= 1'b0;
            r_rx_dv     <= 1'b0;
            r_rx_byte   <= '0;
            r_rx_last   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wait_skip <= (r_state == S_SEND);
            if (w_len_pop) begin
                r_tx_count <= w_len_head;
                r_rem      <= w_len_head;
            end
            if (w_data_pop) begin
                r_tx_byte <= w_data_head;
            end
            if (r_state == S_SEND && r_rem != '0) begin
                r_rem <= r_rem - CW'(1);
            end
            if (w_wr_accept) begin
                r_wr_cnt <= w_len_push ? '0 : w_wr_cnt_inc;
            end
            r_err_len <= w_wr_accept && w_wr_at_max && !i_Wr_Last;
            r_rx_dv   <= i_RX_DV;
            r_rx_byte <= i_RX_Byte;
            r_rx_last <= i_RX_DV && (r_state != S_IDLE) &&
                         (r_rx_cnt == r_tx_count - CW'(1));
            if (r_state == S_IDLE) begin
                r_rx_cnt <= '0;
            end else if (i_RX_DV) begin
                r_rx_cnt <= r_rx_cnt + CW'(1);
            end
        end
    end

    assign o_TX_Count = r_tx_count;
    assign o_TX_Byte  = r_tx_byte;
    assign o_TX_DV    = (r_state == S_SEND);
    assign o_Busy     = (r_state != S_IDLE);
    assign o_Err_Len  = r_err_len;
    assign o_RX_DV    = r_rx_dv;
    assign o_RX_Byte  = r_rx_byte;
    assign o_RX_Last  = r_rx_last;

endmodule

// File: tb/tb_spi_frame_streamer.sv
// Directed bench for spi_frame_streamer with a behavioural loopback SPI master.
module tb_spi_frame_streamer;

    logic       i_Clk;
    logic       i_Rst;
    logic       i_Wr_DV;
    logic [7:0] i_Wr_Byte;
    logic       i_Wr_Last;
    logic       o_Wr_Ready;
    logic [2:0] o_TX_Count;
    logic [7:0] o_TX_Byte;
    logic       o_TX_DV;
    logic       i_TX_Ready;
    logic       i_RX_DV;
    logic [7:0] i_RX_Byte;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       o_RX_Last;
    logic       o_Busy;
    logic       o_Err_Len;

    spi_frame_streamer #(
        .MAX_BYTES_PER_CS (4),
        .DATA_DEPTH       (16),
        .LEN_DEPTH        (4)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Wr_DV    (i_Wr_DV),
        .i_Wr_Byte  (i_Wr_Byte),
        .i_Wr_Last  (i_Wr_Last),
        .o_Wr_Ready (o_Wr_Ready),
        .o_TX_Count (o_TX_Count),
        .o_TX_Byte  (o_TX_Byte),
        .o_TX_DV    (o_TX_DV),
        .i_TX_Ready (i_TX_Ready),
        .i_RX_DV    (i_RX_DV),
        .i_RX_Byte  (i_RX_Byte),
        .o_RX_DV    (o_RX_DV),
        .o_RX_Byte  (o_RX_Byte),
        .o_RX_Last  (o_RX_Last),
        .o_Busy     (o_Busy),
        .o_Err_Len  (o_Err_Len)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    logic [31:0] outs;
    assign outs = {7'b0, o_Wr_Ready, o_Busy, o_Err_Len, o_TX_DV, o_RX_DV, o_RX_Last,
                   o_TX_Count, o_TX_Byte, o_RX_Byte};

    // Logs filled by the master model and the RX monitor
    logic [7:0]  tx_log [32];
    int          tx_n;
    logic [31:0] tx_word;
    logic [31:0] cnt_bits;
    int          cs_n;
    logic [31:0] rx_word;
    logic [31:0] rxl_bits;
    int          rx_n;
    int          err_n;
    logic        hold;

    task automatic clear_logs();
        tx_n = 0; tx_word = '0; cnt_bits = '0; cs_n = 0;
        rx_word = '0; rxl_bits = '0; rx_n = 0; err_n = 0;
    endtask

    // Master model: ready high in idle, one more ready cycle after DV, 8-cycle
    // transfer ending in a looped-back RX_DV, 4-cycle CS-inactive gap after the frame.
    localparam logic [1:0] M_IDLE = 2'd0, M_HOLD1 = 2'd1, M_XFER = 2'd2, M_GAP = 2'd3;
    logic [1:0] m_state;
    int         m_cnt;
    int         m_rem;
    logic [2:0] m_count;
    logic [7:0] m_byte;
    logic       cs_active;

    initial begin
        i_TX_Ready = 1'b1;
        i_RX_DV    = 1'b0;
        i_RX_Byte  = 8'h00;
        m_state    = M_IDLE;
        m_cnt      = 0;
        m_rem      = 0;
        m_count    = '0;
        m_byte     = '0;
        cs_active  = 1'b0;
        forever begin
            tick();
            i_RX_DV = 1'b0;
            if (i_Rst) begin
                m_state    = M_IDLE;
                m_cnt      = 0;
                cs_active  = 1'b0;
                i_TX_Ready = 1'b1;
            end else begin
                case (m_state)
                    M_IDLE:  i_TX_Ready = !hold;
                    M_HOLD1: i_TX_Ready = 1'b1;
                    default: i_TX_Ready = 1'b0;
                endcase
                if (o_TX_DV) begin
                    check_eq("dv_master_idle", {31'b0, m_state == M_IDLE}, 32'd1);
                    check_eq("dv_ready", {31'b0, i_TX_Ready}, 32'd1);
                    if (cs_active) begin
                        check_eq("tx_count_stable", {29'b0, o_TX_Count}, {29'b0, m_count});
                    end else begin
                        cs_active = 1'b1;
                        cs_n++;
                        m_count  = o_TX_Count;
                        m_rem    = int'(o_TX_Count);
                        cnt_bits = {cnt_bits[27:0], 1'b0, o_TX_Count};
                    end
                    if (tx_n < 32) tx_log[tx_n] = o_TX_Byte;
                    tx_n++;
                    tx_word = {tx_word[23:0], o_TX_Byte};
                    m_byte  = o_TX_Byte;
                    m_state = M_HOLD1;
                    $display("tx byte=%02h count=%0d", o_TX_Byte, o_TX_Count);
                end else begin
                    case (m_state)
                        M_HOLD1: begin
                            m_state = M_XFER;
                            m_cnt   = 0;
                        end
                        M_XFER: begin
                            m_cnt++;
                            if (m_cnt == 8) begin
                                i_RX_DV   = 1'b1;
                                i_RX_Byte = m_byte;
                                m_rem--;
                                m_cnt   = 0;
                                m_state = (m_rem <= 0) ? M_GAP : M_IDLE;
                            end
                        end
                        M_GAP: begin
                            m_cnt++;
                            if (m_cnt == 4) begin
                                m_state   = M_IDLE;
                                cs_active = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    initial begin
        forever begin
            tick();
            if (o_RX_DV) begin
                rx_word  = {rx_word[23:0], o_RX_Byte};
                rxl_bits = {rxl_bits[30:0], o_RX_Last};
                rx_n++;
                $display("rx byte=%02h last=%0b", o_RX_Byte, o_RX_Last);
            end
            if (o_Err_Len) err_n++;
        end
    end

    task automatic wr(input logic [7:0] b, input logic last, output logic acc);
        i_Wr_DV   = 1'b1;
        i_Wr_Byte = b;
        i_Wr_Last = last;
        acc       = o_Wr_Ready;
        tick();
        i_Wr_DV   = 1'b0;
        i_Wr_Last = 1'b0;
    endtask

    initial begin
        logic acc;
        int   d;
        int   n_acc;
        int   dv_seen;

        i_Rst = 1'b1; i_Wr_DV = 1'b0; i_Wr_Byte = '0; i_Wr_Last = 1'b0; hold = 1'b0;
        clear_logs();
        repeat (3) tick();
        check_eq("reset_outputs", outs, 32'h0100_0000);
        i_Rst = 1'b0;
        tick();

        // 1: single 4-byte frame
        clear_logs();
        wr(8'hC1, 1'b0, acc); wr(8'hC2, 1'b0, acc); wr(8'hC3, 1'b0, acc); wr(8'hC4, 1'b1, acc);
        d = 1;
        while (!o_TX_DV && d < 20) begin tick(); d++; end
        check_eq("t1_latency", d, 3);
        repeat (200) tick();
        check_eq("t1_tx_bytes", tx_word, 32'hC1C2C3C4);
        check_eq("t1_tx_n", tx_n, 4);
        check_eq("t1_count", cnt_bits, 32'h4);
        check_eq("t1_cs_periods", cs_n, 1);
        check_eq("t1_rx_bytes", rx_word, 32'hC1C2C3C4);
        check_eq("t1_rx_last", rxl_bits, 32'h1);

        // 2: back-to-back frames
        clear_logs();
        wr(8'hA0, 1'b0, acc); wr(8'hA1, 1'b1, acc); wr(8'hB0, 1'b1, acc);
        repeat (200) tick();
        check_eq("t2_tx_bytes", tx_word, 32'h00A0A1B0);
        check_eq("t2_counts", cnt_bits, 32'h21);
        check_eq("t2_cs_periods", cs_n, 2);
        check_eq("t2_rx_last", rxl_bits, 32'h3);

        // 3: length FIFO fills while the master is held off
        clear_logs();
        hold = 1'b1;
        tick();
        n_acc = 0;
        for (int i = 0; i < 16; i++) begin
            wr(8'h30 + 8'(i), 1'b1, acc);
            if (acc) n_acc++;
        end
        check_eq("t3_accepted", n_acc, 4);
        check_eq("t3_wr_ready", {31'b0, o_Wr_Ready}, 32'd0);
        check_eq("t3_no_tx_held", tx_n, 0);
        hold = 1'b0;
        repeat (250) tick();
        check_eq("t3_tx_bytes", tx_word, 32'h30313233);
        check_eq("t3_counts", cnt_bits, 32'h1111);
        check_eq("t3_cs_periods", cs_n, 4);

        // 4: over-length frame is split
        clear_logs();
        for (int i = 10; i < 14; i++) wr(8'(i), 1'b0, acc);
        wr(8'd14, 1'b1, acc);
        repeat (250) tick();
        check_eq("t4_err_len", err_n, 1);
        check_eq("t4_counts", cnt_bits, 32'h41);
        check_eq("t4_tx_n", tx_n, 5);
        check_eq("t4_tx_bytes", tx_word, 32'h0B0C0D0E);
        check_eq("t4_rx_last", rxl_bits, 32'h3);

        // 5: reset mid-frame
        clear_logs();
        wr(8'h50, 1'b0, acc); wr(8'h51, 1'b0, acc); wr(8'h52, 1'b0, acc); wr(8'h53, 1'b1, acc);
        dv_seen = 0;
        d = 0;
        while (dv_seen < 2 && d < 200) begin
            tick();
            if (o_TX_DV) dv_seen++;
            d++;
        end
        check_eq("t5_second_dv", dv_seen, 2);
        i_Rst = 1'b1;
        tick();
        check_eq("t5_reset_outputs", outs, 32'h0100_0000);
        tick();
        i_Rst = 1'b0;
        tick();
        clear_logs();
        wr(8'h55, 1'b1, acc);
        repeat (100) tick();
        check_eq("t5_tx_n", tx_n, 1);
        check_eq("t5_tx_byte", tx_word, 32'h55);
        check_eq("t5_count", cnt_bits, 32'h1);
        check_eq("t5_rx", rx_word, 32'h55);
        check_eq("t5_rx_last", rxl_bits, 32'h1);

        // 6: push and pop in the same cycle with 15 bytes stored
        clear_logs();
        hold = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) wr(8'h60 + 8'(i), (i % 4) == 3, acc);
        check_eq("t6_ready_at_15", {31'b0, o_Wr_Ready}, 32'd1);
        hold = 1'b0;
        d = 0;
        while (!o_Busy && d < 20) begin tick(); d++; end
        check_eq("t6_busy", {31'b0, o_Busy}, 32'd1);
        wr(8'h6F, 1'b1, acc);
        check_eq("t6_push_pop_ready", {31'b0, acc}, 32'd1);
        repeat (400) tick();
        check_eq("t6_tx_n", tx_n, 16);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("t6_order_%0d", i), {24'b0, tx_log[i]}, 32'h60 + i);
        end
        check_eq("t6_counts", cnt_bits, 32'h4444);
        check_eq("t6_cs_periods", cs_n, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
